// File: rtl/ws2812_wheel_gen.sv
// Per-frame colour generator for a WS2812 chain: walks LED indices once per frame
// and emits one {G,R,B} write per LED (rainbow / solid / chase / off, brightness scaled).
module ws2812_wheel_gen #(
    parameter int NUM_LEDS    = 8,
    parameter int FRAME_TICKS = 524288,
    parameter int WRITE_GAP   = 2,
    parameter int HUE_STEP    = 32,
    parameter int HUE_SPEED   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  brightness,
    input  logic [23:0] solid_rgb,
    output logic [7:0]  led_num,
    output logic [23:0] rgb_data,
    output logic        write,
    output logic        frame_done,
    output logic        busy
);

    localparam int             TW     = $clog2(FRAME_TICKS);
    localparam logic [TW-1:0]  T_LAST = TW'(FRAME_TICKS - 1);
    localparam int             GW     = $clog2(WRITE_GAP + 2);
    localparam logic [GW-1:0]  G_LAST = GW'((WRITE_GAP > 0) ? WRITE_GAP - 1 : 0);
    localparam logic [7:0]     L_LAST = 8'(NUM_LEDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_WRITE, S_GAP, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [TW-1:0]   r_timer;
    logic [GW-1:0]   r_gap;
    logic [7:0]      r_idx, r_hue_base, r_chase, r_bri;
    logic [1:0]      r_mode;
    logic [23:0]     r_solid;
    logic            w_tc, w_start, w_last;
    logic [7:0]      w_hoff, w_hue, w_k, w_up, w_dn;
    logic [23:0]     w_wheel, w_raw, w_rgb;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(c) * (16'(b) + 16'd1);
        return 8'(p >> 8);
    endfunction

    assign w_tc    = (r_timer == T_LAST);
    assign w_start = w_tc && enable && (r_state == S_IDLE);
    assign w_last  = (r_idx == L_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_timer <= '0;
        else          r_timer <= w_tc ? '0 : r_timer + TW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_CALC;
            S_CALC:  w_next = S_WRITE;
            S_WRITE: begin
                if (WRITE_GAP == 0) w_next = w_last ? S_DONE : S_CALC;
                else                w_next = S_GAP;
            end
            S_GAP:   if (r_gap == G_LAST) w_next = w_last ? S_DONE : S_CALC;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign write      = (r_state == S_WRITE);
    assign frame_done = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);

    // Hue wheel: three 85-step segments, each ramping one channel up and one down.
    assign w_hoff = r_idx * 8'(HUE_STEP);
    assign w_hue  = r_hue_base + w_hoff;

    always_comb begin
        w_k = w_hue;
        if (w_hue >= 8'd170)     w_k = w_hue - 8'd170;
        else if (w_hue >= 8'd85) w_k = w_hue - 8'd85;
        w_up = w_k * 8'd3;
        w_dn = 8'd255 - w_up;
        if (w_hue < 8'd85)       w_wheel = {w_up, w_dn, 8'd0};
        else if (w_hue < 8'd170) w_wheel = {w_dn, 8'd0, w_up};
        else                     w_wheel = {8'd0, w_up, w_dn};
    end

    always_comb begin
        case (r_mode)
            2'd0:    w_raw = w_wheel;
            2'd1:    w_raw = r_solid;
            2'd2:    w_raw = (r_idx == r_chase) ? r_solid : 24'd0;
            default: w_raw = 24'd0;
        endcase
        w_rgb = {scale(w_raw[23:16], r_bri), scale(w_raw[15:8], r_bri), scale(w_raw[7:0], r_bri)};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx      <= '0;
            r_gap      <= '0;
            r_hue_base <= '0;
            r_chase    <= '0;
            r_mode     <= '0;
            r_bri      <= '0;
            r_solid    <= '0;
            led_num    <= '0;
            rgb_data   <= '0;
        end else begin
            if (w_start) begin
                r_mode  <= mode;
                r_bri   <= brightness;
                r_solid <= solid_rgb;
                r_idx   <= '0;
            end
            if (r_state == S_CALC) begin
                led_num  <= r_idx;
                rgb_data <= w_rgb;
                r_gap    <= '0;
            end
            if (r_state == S_GAP) r_gap <= r_gap + GW'(1);
            // Step to the next LED only when looping back into CALC mid-frame.
            if (w_next == S_CALC && r_state != S_IDLE) r_idx <= r_idx + 8'd1;
            if (r_state == S_DONE) begin
                r_hue_base <= r_hue_base + 8'(HUE_SPEED);
                r_chase    <= (r_chase == L_LAST) ? 8'd0 : r_chase + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_wheel_gen.sv
// Scoreboard bench: the stimulus thread queues expected writes, a monitor thread
// pops and checks them on every write strobe.
module tb_ws2812_wheel_gen;

    logic        clk = 1'b0;
    logic        reset_n, enable;
    logic [1:0]  mode;
    logic [7:0]  brightness;
    logic [23:0] solid_rgb;
    logic [7:0]  led_num;
    logic [23:0] rgb_data;
    logic        write, frame_done, busy;

    typedef struct packed {
        logic [7:0]  led;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0, checks = 0;
    int   cyc = 0, last_w = 0, nwrites = 0;

    ws2812_wheel_gen #(
        .NUM_LEDS(4), .FRAME_TICKS(64), .WRITE_GAP(2), .HUE_STEP(64), .HUE_SPEED(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .brightness(brightness), .solid_rgb(solid_rgb), .led_num(led_num),
        .rgb_data(rgb_data), .write(write), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic push(input logic [7:0] l, input logic [23:0] c);
        exp_t e;
        e.led = l;
        e.rgb = c;
        sb.push_back(e);
    endtask

    task automatic push4(input logic [23:0] c0, input logic [23:0] c1,
                         input logic [23:0] c2, input logic [23:0] c3);
        push(8'd0, c0); push(8'd1, c1); push(8'd2, c2); push(8'd3, c3);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (write) begin
                nwrites++;
                if (sb.size() == 0) begin
                    fail($sformatf("unexpected_write led=%0d rgb=%h", led_num, rgb_data));
                end else begin
                    e = sb.pop_front();
                    chk("led_num", 32'(led_num), 32'(e.led));
                    chk($sformatf("rgb_data[led%0d]", e.led), 32'(rgb_data), 32'(e.rgb));
                    if (led_num != 8'd0) chk("write_spacing", 32'(cyc - last_w), 32'd4);
                    chk("busy_on_write", 32'(busy), 32'd1);
                end
                last_w = cyc;
            end
            if (frame_done) chk("done_after_last_write", 32'(cyc - last_w), 32'd3);
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        if (!seen) fail("timeout_frame_done");
    endtask

    task automatic wait_write(input logic [7:0] l);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (write && led_num == l) seen = 1;
        end
        if (!seen) fail($sformatf("timeout_write_led%0d", l));
    endtask

    initial begin
        logic [7:0] chase_tab [5];
        int n, n0;
        bit seen;
        chase_tab = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};

        reset_n = 1'b0; enable = 1'b1; mode = 2'd0; brightness = 8'd255; solid_rgb = 24'd0;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_led_num", 32'(led_num), 32'd0);
        chk("rst_rgb_data", 32'(rgb_data), 32'd0);

        // Rainbow: hue_base 0, then 16 on the following frame.
        push4(24'h00FF00, 24'hC03F00, 24'h7E0081, 24'h0042BD);
        push4(24'h30CF00, 24'hF00F00, 24'h4E00B1, 24'h00728D);
        reset_n = 1'b1;
        wait_done();
        wait_done();

        mode = 2'd1; solid_rgb = 24'hFF8040; brightness = 8'd127;
        push4(24'h7F4020, 24'h7F4020, 24'h7F4020, 24'h7F4020);
        wait_done();
        brightness = 8'd0;
        push4(24'h0, 24'h0, 24'h0, 24'h0);
        wait_done();

        mode = 2'd2; solid_rgb = 24'h101010; brightness = 8'd255;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 4; i++)
                push(8'(i), (8'(i) == chase_tab[f]) ? 24'h101010 : 24'h0);
            wait_done();
        end

        // Mid-frame mode change is deferred to the next frame.
        mode = 2'd1; solid_rgb = 24'hFF8040;
        push4(24'hFF8040, 24'hFF8040, 24'hFF8040, 24'hFF8040);
        push4(24'h0, 24'h0, 24'h0, 24'h0);
        wait_write(8'd2);
        mode = 2'd3;
        wait_done();
        wait_done();

        mode = 2'd1;
        push4(24'hFF8040, 24'hFF8040, 24'hFF8040, 24'hFF8040);
        wait_write(8'd1);
        enable = 1'b0;
        wait_done();
        @(negedge clk);
        chk("busy_after_last_frame", 32'(busy), 32'd0);
        n0 = nwrites;
        repeat (150) @(negedge clk);
        chk("no_writes_while_disabled", 32'(nwrites), 32'(n0));
        chk("busy_while_disabled", 32'(busy), 32'd0);

        // 12 frames completed so far -> hue_base 192 for LED0.
        enable = 1'b1; mode = 2'd0;
        push(8'd0, 24'h0042BD);
        wait_write(8'd0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_write", 32'(write), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_frame_done", 32'(frame_done), 32'd0);
        chk("abort_led_num", 32'(led_num), 32'd0);
        chk("abort_rgb_data", 32'(rgb_data), 32'd0);
        repeat (3) @(negedge clk);
        push4(24'h00FF00, 24'hC03F00, 24'h7E0081, 24'h0042BD);
        reset_n = 1'b1;
        n = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (write) seen = 1;
        end
        chk("first_write_latency", 32'(n), 32'd65);
        wait_done();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
